sort_column: RTL and testbench
==============================

SORT_COLUMN -- requirements
Module: sort_column

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of each sample and of the result; all statements below use WIDTH=8.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: the reset, asynchronous and active-low; while rst=0 all state is cleared.
REQ-004 Ports in0..in6, input, WIDTH bits each: seven unsigned samples forming one pixel column; order carries no meaning.
REQ-005 Port out, output, WIDTH bits: registered median (4th smallest of 7) of a column sampled 7 register stages earlier.

Function
REQ-006 The block SHALL compute the median of in0..in6 with a pipelined 7-lane odd-even transposition sorting network of 7 stages.
REQ-007 Stage 1 SHALL register the seven inputs after compare-exchange on lane pairs (0,1),(2,3),(4,5); lane 6 passes through.
REQ-008 Even-numbered stages SHALL compare-exchange pairs (1,2),(3,4),(5,6), with lane 0 passing through; odd-numbered stages SHALL use the stage-1 pairing.
REQ-009 Each compare-exchange SHALL place the smaller value (unsigned compare) in the lower-numbered lane and the larger in the higher-numbered lane.
REQ-010 On ties, the lower lane SHALL keep its own value; no swap occurs.
REQ-011 Every stage SHALL be a WIDTH x 7 register bank; no combinational path SHALL exist from any input to out.
REQ-012 After stage 7 the lanes SHALL be fully ascending; out SHALL be driven directly from stage-7 lane 3.
REQ-013 Latency: values on in0..in6 at rising edge n SHALL appear on out immediately after rising edge n+6, i.e. 7 register stages.
REQ-014 Throughput SHALL be one column per clock; a new column may be applied every cycle with no stalls and no handshake.
REQ-015 Arithmetic SHALL be unsigned WIDTH-bit comparison only; no widening and no overflow are possible.
REQ-016 The block SHALL have no valid or enable signal; out during the first 6 edges after reset release reflects flushed reset zeros or partially flushed data.

Reset
REQ-017 While rst=0, all stage registers and out SHALL be cleared to 0 asynchronously, independent of clk.
REQ-018 After rst rises, the first rising edge SHALL sample the inputs into stage 1.
REQ-019 Reset asserted mid-stream SHALL discard all in-flight columns immediately; out=0 until new data has traversed 7 stages after release.
REQ-020 The inputs SHALL have no effect on any register while rst=0.

Verification
REQ-021 Hold rst=0 with in0..in6=0,1,2,30,40,5,6 -> out=0 throughout; release rst, toggle clk (20 ns period) -> out=5 after the 7th edge and remains 5.
REQ-022 All inputs=255 for 7 edges -> out=255; all inputs=0 -> out=0.
REQ-023 Descending column 70,60,50,40,30,20,10 -> out=40; column with duplicates 9,9,3,9,1,9,2 -> out=9.
REQ-024 Streaming: apply a different column each cycle (for example medians 5, 40, 9, 255) -> out shows the matching medians on consecutive cycles, each 7 edges after its column was applied.
REQ-025 Assert rst=0 between clock edges while data is in flight -> out drops to 0 at once without a clock edge; after release, out shows only post-reset medians.
REQ-026 Randomized check: 1000 random columns compared against a reference median with a 7-cycle alignment -> zero mismatches.

Source files
------------

// File: rtl/sort_column.sv
// sort_column: 7-stage pipelined odd-even transposition sort of a 7-sample column, median out.
// Lane 3 of the final stage is the median; every stage is a registered 7-lane bank.
module sort_column #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] st  [7][7];
    logic [WIDTH-1:0] src [7][7];
    logic [WIDTH-1:0] nx  [7][7];

    always_comb begin
        src[0][0] = in0;
        src[0][1] = in1;
        src[0][2] = in2;
        src[0][3] = in3;
        src[0][4] = in4;
        src[0][5] = in5;
        src[0][6] = in6;
        for (int k = 1; k < 7; k++)
            for (int l = 0; l < 7; l++)
                src[k][l] = st[k-1][l];
        for (int k = 0; k < 7; k++)
            for (int l = 0; l < 7; l++)
                nx[k][l] = src[k][l];
        // index k holds stage k+1: odd stages pair from lane 0, even stages from lane 1
        for (int k = 0; k < 7; k++)
            for (int p = k % 2; p < 6; p += 2) begin
                nx[k][p]   = (src[k][p+1] < src[k][p]) ? src[k][p+1] : src[k][p];
                nx[k][p+1] = (src[k][p+1] < src[k][p]) ? src[k][p]   : src[k][p+1];
            end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 7; k++)
                for (int l = 0; l < 7; l++)
                    st[k][l] <= '0;
        end else begin
            for (int k = 0; k < 7; k++)
                for (int l = 0; l < 7; l++)
                    st[k][l] <= nx[k][l];
        end
    end

    assign out = st[6][3];
endmodule

// File: tb/tb_sort_column.sv
// tb_sort_column: scoreboard bench for sort_column; expected medians queued at drive time,
// popped and compared seven edges later.
module tb_sort_column;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0, in4 = '0, in5 = '0, in6 = '0;
    logic [7:0] out;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] q[$];

    sort_column #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6),
        .out(out)
    );

    always #10 clk = ~clk;

    function automatic logic [55:0] col7(input logic [7:0] a, b, c, d, e, f, g);
        return {g, f, e, d, c, b, a};
    endfunction

    // rank-based reference: the median has at most 3 smaller and at least 4 smaller-or-equal
    function automatic logic [7:0] med(input logic [55:0] v);
        logic [7:0] r;
        int lt, eq;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            lt = 0;
            eq = 0;
            for (int j = 0; j < 7; j++) begin
                if (v[8*j +: 8] < v[8*i +: 8]) lt++;
                else if (v[8*j +: 8] == v[8*i +: 8]) eq++;
            end
            if (lt <= 3 && lt + eq >= 4) r = v[8*i +: 8];
        end
        return r;
    endfunction

    task automatic drive(input logic [55:0] v);
        in0 = v[7:0];   in1 = v[15:8];  in2 = v[23:16]; in3 = v[31:24];
        in4 = v[39:32]; in5 = v[47:40]; in6 = v[55:48];
    endtask

    task automatic step(input logic [55:0] v, input string name);
        logic [7:0] exp_v;
        drive(v);
        @(posedge clk);
        q.push_back(med(v));
        #1;
        if (q.size() >= 7) begin
            exp_v = q.pop_front();
            vectors++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL %s: out=%0d expected=%0d at %0t", name, out, exp_v, $time);
            end
        end
    endtask

    task automatic prefill();
        q.delete();
        repeat (6) q.push_back(8'd0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(col7(0, 1, 2, 30, 40, 5, 6));
        repeat (3) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold: out=%0d expected=0", out);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        prefill();
        repeat (10) step(col7(0, 1, 2, 30, 40, 5, 6), "reset_release");
    endtask

    task automatic test_extremes();
        repeat (7) step(col7(255, 255, 255, 255, 255, 255, 255), "all_255");
        repeat (7) step(col7(0, 0, 0, 0, 0, 0, 0), "all_0");
    endtask

    task automatic test_patterns();
        repeat (7) step(col7(70, 60, 50, 40, 30, 20, 10), "descending");
        repeat (7) step(col7(9, 9, 3, 9, 1, 9, 2), "duplicates");
        step(col7(1, 2, 3, 4, 5, 6, 7), "ascending");
        step(col7(200, 0, 255, 128, 127, 129, 1), "mixed");
    endtask

    task automatic test_back_to_back();
        step(col7(0, 1, 2, 30, 40, 5, 6), "stream_5");
        step(col7(70, 60, 50, 40, 30, 20, 10), "stream_40");
        step(col7(9, 9, 3, 9, 1, 9, 2), "stream_9");
        step(col7(255, 255, 255, 255, 255, 255, 255), "stream_255");
        repeat (7) step(col7(3, 3, 3, 3, 3, 3, 3), "stream_drain");
    endtask

    task automatic test_midreset();
        step(col7(10, 20, 30, 40, 50, 60, 70), "inflight_a");
        step(col7(99, 98, 97, 96, 95, 94, 93), "inflight_b");
        step(col7(5, 250, 5, 250, 5, 250, 5), "inflight_c");
        #4 rst = 1'b0;
        #1;
        vectors++;
        if (out !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: out=%0d expected=0", out);
        end
        drive(col7(170, 170, 170, 170, 170, 170, 170));
        repeat (2) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out !== 8'd0) begin
                errors++;
                $display("FAIL reset_ignores_inputs: out=%0d expected=0", out);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        prefill();
        step(col7(11, 22, 33, 44, 55, 66, 77), "post_reset_a");
        step(col7(8, 8, 8, 1, 1, 1, 200), "post_reset_b");
        repeat (7) step(col7(0, 0, 0, 0, 0, 0, 0), "post_reset_drain");
    endtask

    task automatic test_random();
        logic [55:0] v;
        for (int n = 0; n < 1000; n++) begin
            for (int l = 0; l < 7; l++)
                v[8*l +: 8] = (n % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            step(v, "random");
        end
        repeat (7) step(col7(0, 0, 0, 0, 0, 0, 0), "random_drain");
    endtask

    initial begin
        test_reset();
        test_extremes();
        test_patterns();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
